// File: rtl/approx_adder_pkg.sv
// Shared definitions for the pipelined approximate ripple-carry adder:
// per-bit cell mode and the segment-width helper.
package approx_adder_pkg;

    typedef enum logic {
        CELL_EXACT  = 1'b0,
        CELL_APPROX = 1'b1
    } cell_mode_e;

    // Bits per pipeline stage; the last stage takes whatever is left over.
    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/approx_fa_cell.sv
// One-bit adder cell, switchable between an exact full adder and the cheap
// approximate cell (S = X & ~Z, carry forced high).
module approx_fa_cell
    import approx_adder_pkg::*;
(
    input  logic       X,
    input  logic       Y,
    input  logic       Z,
    input  cell_mode_e mode,
    output logic       S,
    output logic       Cout
);

    always_comb begin
        if (mode == CELL_APPROX) begin
            S    = X & ~Z;
            Cout = 1'b1;
        end else begin
            S    = X ^ Y ^ Z;
            Cout = (X & Y) | (X & Z) | (Y & Z);
        end
    end

endmodule

// File: rtl/approx_rca_pipe.sv
// Pipelined ripple-carry adder with per-beat selectable approximate LSBs.
// Each stage ripples one segment and hands carry, partial sum and operands on.
module approx_rca_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 7,
    parameter int STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_exact,
    output logic [15:0]      txn_cnt
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            c_q, c_d, c_nxt;
    logic [STAGES-1:0]            tag_q, tag_d;
    logic [STAGES-1:0]            ready, take;
    logic [STAGES-1:0]            src_c, src_tag;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_nxt;
    logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_sum;
    logic [WIDTH-1:0]             cell_s;
    logic                         rdy_en_q;
    logic [15:0]                  txn_cnt_q, txn_cnt_d;

    // Operand bits already consumed by earlier stages are carried but never read.
    logic unused_bits;
    assign unused_bits = ^{src_a, src_b, src_sum, a_q, b_q};

    for (genvar s = 0; s < STAGES; s++) begin : g_src
        if (s == 0) begin : g_in
            assign src_a[s]   = in_a;
            assign src_b[s]   = in_b;
            assign src_sum[s] = '0;
            assign src_c[s]   = 1'b0;
            assign src_tag[s] = in_exact;
        end else begin : g_reg
            assign src_a[s]   = a_q[s-1];
            assign src_b[s]   = b_q[s-1];
            assign src_sum[s] = sum_q[s-1];
            assign src_c[s]   = c_q[s-1];
            assign src_tag[s] = tag_q[s-1];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int SI = i / SEG;
        logic       z, s_bit, co;
        cell_mode_e mode;

        if (i % SEG == 0) begin : g_head
            assign z = src_c[SI];
        end else begin : g_body
            assign z = g_bit[i-1].co;
        end

        if (i < APPROX_BITS) begin : g_apx
            assign mode = src_tag[SI] ? CELL_EXACT : CELL_APPROX;
        end else begin : g_exa
            assign mode = CELL_EXACT;
        end

        approx_fa_cell u_fa (
            .X    (src_a[SI][i]),
            .Y    (src_b[SI][i]),
            .Z    (z),
            .mode (mode),
            .S    (s_bit),
            .Cout (co)
        );

        assign cell_s[i] = s_bit;
    end

    // Stages with no bits left (STAGES not dividing WIDTH) just forward the carry.
    for (genvar s = 0; s < STAGES; s++) begin : g_cout
        localparam int LO = s * SEG;
        localparam int HI = ((s + 1) * SEG < WIDTH) ? (s + 1) * SEG : WIDTH;
        if (LO < WIDTH) begin : g_seg
            assign c_nxt[s] = g_bit[HI-1].co;
        end else begin : g_empty
            assign c_nxt[s] = src_c[s];
        end
    end

    always_comb begin
        sum_nxt = '0;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < WIDTH; i++) begin
                sum_nxt[s][i] = (i / SEG == s) ? cell_s[i] : src_sum[s][i];
            end
        end
    end

    // A stage can load when empty or when its occupant leaves this cycle.
    always_comb begin
        ready       = '0;
        take        = '0;
        ready[LAST] = ~valid_q[LAST] | out_ready;
        for (int s = LAST - 1; s >= 0; s--) begin
            ready[s] = ~valid_q[s] | ready[s+1];
        end
        in_ready = rdy_en_q & ready[0];
        take[0]  = in_valid & in_ready;
        for (int s = 1; s < STAGES; s++) begin
            take[s] = valid_q[s-1] & ready[s];
        end
    end

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        c_d       = c_q;
        tag_d     = tag_q;
        txn_cnt_d = txn_cnt_q;
        for (int s = 0; s < STAGES; s++) begin
            if (ready[s]) valid_d[s] = take[s];
            if (take[s]) begin
                a_d[s]   = src_a[s];
                b_d[s]   = src_b[s];
                sum_d[s] = sum_nxt[s];
                c_d[s]   = c_nxt[s];
                tag_d[s] = src_tag[s];
            end
        end
        if (valid_q[LAST] && out_ready && txn_cnt_q != 16'hFFFF) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
        end
    end

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q  <= 1'b0;
            valid_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            c_q       <= '0;
            tag_q     <= '0;
            txn_cnt_q <= '0;
        end else begin
            rdy_en_q  <= 1'b1;
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            c_q       <= c_d;
            tag_q     <= tag_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign out_sum   = {c_q[LAST], sum_q[LAST]};
    assign out_exact = tag_q[LAST];
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: doc/approx_rca_pipe.md
APPROX_RCA_PIPE -- requirements
Module: approx_rca_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 Parameter APPROX_BITS, default 7: number of LSB positions using the approximate cell, legal range 0..WIDTH-1.
REQ-003 Parameter STAGES, default 2: pipeline depth, legal range 1..WIDTH; segment width SEG = ceil(WIDTH/STAGES); the last segment takes the remainder.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  the operand beat is valid.
REQ-007 in_ready  out  1  the block accepts a beat this cycle.
REQ-008 in_a, in_b  in  WIDTH  operands, unsigned.
REQ-009 in_exact  in  1  1 = every bit uses an exact full adder for this beat; 0 = approximate LSBs.
REQ-010 out_valid  out  1  the result beat is valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_sum  out  WIDTH+1  the sum; the MSB is the final carry.
REQ-013 out_exact  out  1  the in_exact tag carried with the beat.
REQ-014 txn_cnt  out  16  count of completed output transfers.

Function
REQ-015 Approximate cell: S = X & ~Cin; Cout = 1 for all inputs.
REQ-016 Exact cell: S = X^Y^Cin; Cout = majority(X,Y,Cin).
REQ-017 Bit i uses the approximate cell when i < APPROX_BITS and the beat's tag is 0; otherwise it uses the exact cell.
REQ-018 The carry-in of bit 0 is 0; carries ripple LSB to MSB.
REQ-019 Stage s computes its segment's bits from the registered carry and upper operand bits of stage s-1.
REQ-020 Stage s registers the partial sum, the carry-out, the unconsumed operand bits, the tag and a valid bit.
REQ-021 Latency is exactly STAGES cycles from acceptance (in_valid & in_ready) to out_valid when there is no backpressure.
REQ-022 Throughput is one beat per cycle.
REQ-023 Stage k loads when it is empty or its content moves forward in the same cycle; bubbles collapse.
REQ-024 in_ready = !valid[0] | advance[0]; in_ready does not depend combinationally on in_valid.
REQ-025 An output transfer occurs when out_valid & out_ready.
REQ-026 out_sum, out_exact and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-027 A full pipeline with out_ready=0 deasserts in_ready; no beat is lost or duplicated.
REQ-028 An acceptance and an output transfer in the same cycle on a full pipeline are both honoured.
REQ-029 txn_cnt increments on each output transfer and saturates at 0xFFFF.
REQ-030 in_exact is sampled per beat; beats of mixed modes may be in flight together.
REQ-031 With APPROX_BITS=0, out_sum = in_a + in_b for every beat.

Reset
REQ-032 rst_n low clears all valid bits, out_valid, out_sum, out_exact and txn_cnt to 0 immediately, without waiting for clk.
REQ-033 During reset in_ready = 0; in_ready rises no earlier than the first clk edge after rst_n deasserts.
REQ-034 Beats in flight when reset asserts are discarded.

Structure
REQ-035 Package approx_adder_pkg holds the cell-mode constants (CELL_EXACT, CELL_APPROX) and the SEG computation function.
REQ-036 One sub-module, approx_fa_cell (X, Y, Z, mode -> S, Cout), is instantiated per bit.
REQ-037 The segment loop is generated; no per-width hand instantiation.

Verification
REQ-038 WIDTH=8, APPROX_BITS=7, STAGES=2, exact=0: a=0x00, b=0x00 -> out_sum=0x080 after 2 cycles.
REQ-039 Same configuration, exact=0: a=0xFF, b=0xFF -> 0x181; exact=1 -> 0x1FE; out_exact follows the tag.
REQ-040 Same configuration, exact=0: a=0x55, b=0x0F -> 0x081; back-to-back beats give one result per cycle.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once 2 beats are held; results are stable; release -> all beats arrive in order.
REQ-042 Assert rst_n=0 mid-stream -> out_valid=0 and txn_cnt=0 with no clk edge required; no stale beat after release.
REQ-043 Random stimulus with APPROX_BITS=0 compared against a + b; txn_cnt is forced to 0xFFFE and 3 transfers are made -> 0xFFFF.
